// File: rtl/vector_alu.sv
// Single-lane element ALU: one element pair in, one result element out the same cycle,
// plus a registered copy of that result for pipelined integration.
module vector_alu #(
  parameter int LANE_INDEX = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  PREV_VSEW,
  input  logic [2:0]  CUR_VSEW,
  input  logic        vm,
  input  logic [63:0] vs1,
  input  logic [63:0] vs2,
  input  logic        mask,
  input  logic [31:0] imm,
  input  logic [31:0] rs,
  input  logic [2:0]  alu_signal,
  input  logic [1:0]  vec_operand_type,
  input  logic [5:0]  opcode,
  output logic [63:0] result,
  output logic [63:0] result_q
);

  function automatic logic [63:0] sew_mask(input logic [1:0] sew);
    case (sew)
      2'd0:    sew_mask = 64'h0000_0000_0000_00FF;
      2'd1:    sew_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    sew_mask = 64'h0000_0000_FFFF_FFFF;
      default: sew_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] sew_sext(input logic [63:0] x, input logic [1:0] sew);
    case (sew)
      2'd0:    sew_sext = {{56{x[7]}}, x[7:0]};
      2'd1:    sew_sext = {{48{x[15]}}, x[15:0]};
      2'd2:    sew_sext = {{32{x[31]}}, x[31:0]};
      default: sew_sext = x;
    endcase
  endfunction

  logic        w_sew_ok;
  logic [1:0]  w_ps;
  logic [1:0]  w_cs;
  logic [63:0] w_ws_mask;
  logic [63:0] w_wd_mask;
  logic [63:0] w_vs2_s;
  logic [63:0] w_vs1_s;
  logic [63:0] w_rs_s;
  logic [63:0] w_imm_s;
  logic [63:0] w_op2;
  logic        w_cin;
  logic [64:0] w_sum65;
  logic [64:0] w_dif65;
  logic        w_carry;
  logic [1:0]  w_lk;
  logic [1:0]  w_src_sew;
  logic [63:0] w_raw;
  logic        w_ok;
  logic        w_carry_op;
  logic [63:0] w_result;
  logic        w_unused;
  logic [63:0] r_result_q;

  assign w_sew_ok  = ~PREV_VSEW[2] & ~CUR_VSEW[2];
  assign w_ps      = PREV_VSEW[1:0];
  assign w_cs      = CUR_VSEW[1:0];
  assign w_ws_mask = sew_mask(w_ps);
  assign w_wd_mask = sew_mask(w_cs);

  // Scalars are sign-extended to 64 first so that a 64-bit source sees a signed scalar.
  assign w_vs2_s = vs2 & w_ws_mask;
  assign w_vs1_s = vs1 & w_ws_mask;
  assign w_rs_s  = {{32{rs[31]}}, rs} & w_ws_mask;
  assign w_imm_s = {{32{imm[31]}}, imm} & w_ws_mask;

  always_comb begin
    w_op2 = w_vs1_s;
    case (vec_operand_type)
      2'b01:   w_op2 = w_rs_s;
      2'b10:   w_op2 = w_imm_s;
      default: w_op2 = w_vs1_s;
    endcase
  end

  assign w_cin   = ~vm & mask;
  assign w_sum65 = {1'b0, w_vs2_s} + {1'b0, w_op2} + {64'b0, w_cin};
  // Operands are zero-extended, so a negative difference always shows up in bit 64.
  assign w_dif65 = {1'b0, w_vs2_s} - {1'b0, w_op2} - {64'b0, w_cin};

  always_comb begin
    w_carry = w_sum65[64];
    case (w_ps)
      2'd0:    w_carry = w_sum65[8];
      2'd1:    w_carry = w_sum65[16];
      2'd2:    w_carry = w_sum65[32];
      default: w_carry = w_sum65[64];
    endcase
  end

  always_comb begin
    w_lk = 2'd1;
    if (opcode == 6'd14 || opcode == 6'd17) w_lk = 2'd2;
    else if (opcode == 6'd15 || opcode == 6'd18) w_lk = 2'd3;
  end
  assign w_src_sew = w_cs - w_lk;

  always_comb begin
    w_raw      = 64'd0;
    w_ok       = 1'b1;
    w_carry_op = 1'b0;
    case (opcode)
      6'd0: begin w_raw = w_vs2_s + w_op2; w_ok = (w_cs == w_ps); end
      6'd1: begin w_raw = w_vs2_s - w_op2; w_ok = (w_cs == w_ps); end
      6'd2: begin w_raw = w_vs2_s + w_op2; w_ok = (w_ps != 2'd3) && (w_cs == w_ps + 2'd1); end
      6'd3: begin w_raw = w_vs2_s - w_op2; w_ok = (w_ps != 2'd3) && (w_cs == w_ps + 2'd1); end
      6'd4: begin
        w_raw = sew_sext(w_vs2_s, w_ps) + sew_sext(w_op2, w_ps);
        w_ok  = (w_ps != 2'd3) && (w_cs == w_ps + 2'd1);
      end
      6'd5: begin
        w_raw = sew_sext(w_vs2_s, w_ps) - sew_sext(w_op2, w_ps);
        w_ok  = (w_ps != 2'd3) && (w_cs == w_ps + 2'd1);
      end
      6'd6:  begin w_raw = w_sum65[63:0]; w_carry_op = 1'b1; end
      6'd7:  begin w_raw = w_dif65[63:0]; w_carry_op = 1'b1; end
      6'd8:  begin w_raw = {63'd0, w_carry}; w_carry_op = 1'b1; end
      6'd9:  begin w_raw = {63'd0, w_dif65[64]}; w_carry_op = 1'b1; end
      6'd10: w_raw = w_vs2_s + w_vs1_s * w_rs_s;
      6'd11: w_raw = w_vs2_s - w_vs1_s * w_rs_s;
      6'd12: w_raw = w_vs2_s * w_rs_s + w_vs1_s;
      6'd13, 6'd14, 6'd15: begin
        if (w_cs < w_lk) w_raw = 64'd0;
        else             w_raw = vs2 & sew_mask(w_src_sew);
      end
      6'd16, 6'd17, 6'd18: begin
        if (w_cs < w_lk) w_raw = 64'd0;
        else             w_raw = sew_sext(vs2, w_src_sew);
      end
      default: w_ok = 1'b0;
    endcase
    // Masked-off elements pass the old destination through; carry ops use vm as carry-in instead.
    if (!w_carry_op && !vm && !mask) w_raw = vs2;
  end

  assign w_result = (alu_signal == 3'b001 && w_sew_ok && w_ok) ? (w_raw & w_wd_mask) : 64'd0;
  assign result   = w_result;

  always_ff @(posedge clk) begin
    if (rst) r_result_q <= 64'd0;
    else     r_result_q <= w_result;
  end
  assign result_q = r_result_q;

  assign w_unused = ^{LANE_INDEX != 0, w_sum65, w_dif65};

endmodule

// File: tb/tb_vector_alu.sv
// Directed test-plan steps followed by randomized elements, checked against an
// arithmetic reference model of the lane ALU.
module tb_vector_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  prev_vsew;
  logic [2:0]  cur_vsew;
  logic        vm;
  logic [63:0] vs1;
  logic [63:0] vs2;
  logic        mask;
  logic [31:0] imm;
  logic [31:0] rs;
  logic [2:0]  alu_signal;
  logic [1:0]  vec_operand_type;
  logic [5:0]  opcode;
  logic [63:0] result;
  logic [63:0] result_q;

  int checks = 0;
  int errors = 0;

  vector_alu #(0) dut (
    .clk(clk), .rst(rst), .PREV_VSEW(prev_vsew), .CUR_VSEW(cur_vsew), .vm(vm),
    .vs1(vs1), .vs2(vs2), .mask(mask), .imm(imm), .rs(rs), .alu_signal(alu_signal),
    .vec_operand_type(vec_operand_type), .opcode(opcode), .result(result), .result_q(result_q)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // reference model: plain wide arithmetic on element widths in bits
  function automatic logic [127:0] trunc(input logic [127:0] x, input int w);
    return x & ((128'd1 << w) - 128'd1);
  endfunction

  function automatic logic [127:0] sx(input logic [127:0] x, input int w);
    logic [127:0] t;
    t = trunc(x, w);
    if (t[w-1]) t = t | ~((128'd1 << w) - 128'd1);
    return t;
  endfunction

  function automatic logic [63:0] ref_alu();
    int ws, wd, k, srcw;
    logic [127:0] a, b, m1, scal, op2, cin, t;
    bit valid, carry_op;
    if (alu_signal != 3'b001 || prev_vsew > 3 || cur_vsew > 3) return 64'd0;
    ws   = 8 << prev_vsew;
    wd   = 8 << cur_vsew;
    a    = trunc({64'd0, vs2}, ws);
    m1   = trunc({64'd0, vs1}, ws);
    scal = trunc(sx({96'd0, rs}, 32), ws);
    b    = trunc(sx({96'd0, imm}, 32), ws);
    op2  = (vec_operand_type == 2'b01) ? scal : (vec_operand_type == 2'b10) ? b : m1;
    cin  = (!vm && mask) ? 128'd1 : 128'd0;
    valid = 1; carry_op = 0; t = 0;
    case (opcode)
      0: begin valid = (wd == ws); t = a + op2; end
      1: begin valid = (wd == ws); t = a - op2; end
      2: begin valid = (wd == 2 * ws); t = a + op2; end
      3: begin valid = (wd == 2 * ws); t = a - op2; end
      4: begin valid = (wd == 2 * ws); t = sx(a, ws) + sx(op2, ws); end
      5: begin valid = (wd == 2 * ws); t = sx(a, ws) - sx(op2, ws); end
      6: begin carry_op = 1; t = a + op2 + cin; end
      7: begin carry_op = 1; t = a - op2 - cin; end
      8: begin carry_op = 1; t = ((a + op2 + cin) >> ws) & 128'd1; end
      9: begin carry_op = 1; t = (a < op2 + cin) ? 128'd1 : 128'd0; end
      10: t = a + m1 * scal;
      11: t = a - m1 * scal;
      12: t = a * scal + m1;
      13, 14, 15, 16, 17, 18: begin
        k = (opcode == 13 || opcode == 16) ? 2 : (opcode == 14 || opcode == 17) ? 4 : 8;
        srcw = wd / k;
        if (srcw < 8) t = 0;
        else if (opcode <= 15) t = trunc({64'd0, vs2}, srcw);
        else t = sx({64'd0, vs2}, srcw);
      end
      default: valid = 0;
    endcase
    if (!valid) return 64'd0;
    if (!carry_op && !vm && !mask) return trunc({64'd0, vs2}, wd);
    return trunc(t, wd);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: inputs are already set; check result now and result_q after the next edge
  task automatic step(input string tag);
    logic [63:0] exp;
    #1;
    exp = ref_alu();
    check({tag, "/result"}, result, exp);
    @(posedge clk);
    #1;
    check({tag, "/result_q"}, result_q, exp);
  endtask

  task automatic set_op(input logic [2:0] p, input logic [2:0] c, input logic [5:0] op,
                        input logic [1:0] ty, input logic v, input logic m);
    prev_vsew = p; cur_vsew = c; opcode = op; vec_operand_type = ty; vm = v; mask = m;
    alu_signal = 3'b001;
  endtask

  initial begin
    rst = 1'b1; vs1 = 0; vs2 = 0; imm = 0; rs = 0;
    set_op(3'd0, 3'd0, 6'd0, 2'b00, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", result_q, 64'd0);
    rst = 1'b0;

    // ADD 8-bit wraps
    set_op(3'd0, 3'd0, 6'd0, 2'b00, 1'b1, 1'b0); vs2 = 64'hF0; vs1 = 64'h20;
    step("add8");
    check("add8_const", result_q, 64'h10);

    // SUB 32-bit with scalar
    set_op(3'd2, 3'd2, 6'd1, 2'b01, 1'b1, 1'b0); vs2 = 64'd5; rs = 32'd7;
    step("sub32");
    check("sub32_const", result, 64'h0000_0000_FFFF_FFFE);

    // widening 8 -> 16
    set_op(3'd0, 3'd1, 6'd4, 2'b00, 1'b1, 1'b0); vs2 = 64'h80; vs1 = 64'h80;
    step("wadd");
    check("wadd_const", result, 64'hFF00);
    opcode = 6'd2;
    step("waddu");
    check("waddu_const", result, 64'h0100);

    // carry-in from mask
    set_op(3'd0, 3'd0, 6'd8, 2'b00, 1'b0, 1'b1); vs2 = 64'hFF; vs1 = 64'h00;
    step("madc");
    check("madc_const", result, 64'd1);
    opcode = 6'd6;
    step("adc");
    check("adc_const", result, 64'd0);

    // SEXT4 into 32-bit
    set_op(3'd0, 3'd2, 6'd17, 2'b00, 1'b1, 1'b0); vs2 = 64'h8F;
    step("sext4");
    check("sext4_const", result, 64'hFFFF_FF8F);

    // masked-off element passes through
    set_op(3'd1, 3'd1, 6'd0, 2'b00, 1'b0, 1'b0); vs2 = 64'h1234; vs1 = 64'h1111;
    step("masked");
    check("masked_const", result, 64'h1234);

    // invalid opcode / idle signal
    set_op(3'd0, 3'd0, 6'd63, 2'b00, 1'b1, 1'b0); vs2 = 64'h55; vs1 = 64'h22;
    step("undef_op");
    check("undef_op_const", result, 64'd0);
    opcode = 6'd0; alu_signal = 3'b000;
    step("idle");
    check("idle_const", result, 64'd0);

    // mid-operation reset clears only result_q
    set_op(3'd0, 3'd0, 6'd0, 2'b00, 1'b1, 1'b0); vs2 = 64'h01; vs1 = 64'h02;
    step("pre_rst");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_q", result_q, 64'd0);
    check("rst_result", result, 64'h03);
    rst = 1'b0;

    // randomized elements, mostly legal width pairings
    for (int i = 0; i < 400; i++) begin
      int p, c, op;
      op = $urandom_range(0, 19);
      p  = $urandom_range(0, 3);
      if (op >= 2 && op <= 5) c = (p < 3) ? p + 1 : 3;
      else if (op >= 13 && op <= 18) begin c = $urandom_range(0, 3); p = $urandom_range(0, 3); end
      else c = p;
      if ($urandom_range(0, 15) == 0) c = $urandom_range(0, 7);
      if ($urandom_range(0, 31) == 0) p = $urandom_range(0, 7);
      set_op(3'(p), 3'(c), 6'(op), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 15) == 0) alu_signal = 3'($urandom_range(0, 7));
      vs1 = {$urandom, $urandom};
      vs2 = {$urandom, $urandom};
      imm = $urandom;
      rs  = $urandom;
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_alu.md
# vector_alu

Single-lane element ALU of the vector function unit. Each lane instance takes one element pair, plus the scalar operands and decoded control from the dispatcher, and produces one result element. The result feeds the recaller in the same cycle. A registered copy of the result is also provided for pipelined integration.

## Interface
- `LANE_INDEX`, default 0: lane number, passed positionally as `#(i)`. It only identifies the lane and has no functional effect.
- `clk`  in  1  clock (one clock domain).
- `rst`  in  1  reset, synchronous and active-high; clears `result_q`.
- `PREV_VSEW`  in  3  source element width: 000=8b, 001=16b, 010=32b, 011=64b.
- `CUR_VSEW`  in  3  destination element width, same encoding.
- `vm`  in  1  1 = unmasked; 0 = masked, or carry/borrow-in for ADC/SBC/MADC/MSBC.
- `vs1`  in  64  element of vs1, right-aligned at `PREV_VSEW` width.
- `vs2`  in  64  element of vs2, right-aligned. For MACC/NMSAC/MADD it is the accumulator (old vd).
- `mask`  in  1  this element's mask bit.
- `imm`  in  32  immediate, used by OPIVI.
- `rs`  in  32  scalar, used by OPIVX and by the multiply ops.
- `alu_signal`  in  3  3'b001 = execute; any other value gives `result`=0.
- `vec_operand_type`  in  2  00=OPIVV, 01=OPIVX, 10=OPIVI, 11=OPMVV.
- `opcode`  in  6  operation:
  - 0 ADD, 1 SUB, 2 WADDU, 3 WSUBU, 4 WADD, 5 WSUB
  - 6 ADC, 7 SBC, 8 MADC, 9 MSBC
  - 10 MACC, 11 NMSAC, 12 MADD
  - 13/14/15 ZEXT2/4/8, 16/17/18 SEXT2/4/8
- `result`  out  64  combinational result, zero-extended above `CUR_VSEW` width.
- `result_q`  out  64  registered `result`; resets to 0.

## Operation
- Widths: Ws = width(`PREV_VSEW`), Wd = width(`CUR_VSEW`).
  - Operands are truncated to Ws bits.
  - The result is computed modulo 2^Wd, then zero-extended to 64 bits.
- Second operand `op2`:
  - OPIVV / OPMVV: `vs1`.
  - OPIVX: `rs`.
  - OPIVI: `imm`.
  - Scalars are sign-extended or truncated to Ws.
- Operations:
  - ADD / SUB: `vs2 ± op2`; requires Wd = Ws.
  - WADDU / WSUBU: zero-extend both operands to Wd, then add or subtract. Requires Wd = 2·Ws.
  - WADD / WSUB: same as WADDU / WSUBU but with sign extension.
  - ADC: `vs2 + op2 + cin`; SBC: `vs2 − op2 − cin`. Here cin = `mask` when `vm`=0, else 0.
  - MADC: bit0 = carry-out of `vs2 + op2 + cin` at Ws; bits 63:1 = 0.
  - MSBC: bit0 = borrow-out of `vs2 − op2 − cin` at Ws; bits 63:1 = 0.
  - MACC: `vs2 + vs1·rs`. NMSAC: `vs2 − vs1·rs`. MADD: `vs2·rs + vs1`. All take the low Wd bits of the product.
  - ZEXTk / SEXTk: take the low Wd/k bits of `vs2` and zero- or sign-extend them to Wd. If Wd/k < 8, the result is 0.
- Masking, for all opcodes except ADC/SBC/MADC/MSBC: if `vm`=0 and `mask`=0, `result` = `vs2` truncated to Wd (element passes through unchanged).
- Result forced to 0 when any of the following holds:
  - the opcode is undefined;
  - `CUR_VSEW` or `PREV_VSEW` is greater than 3;
  - the width precondition of the opcode is violated;
  - `alu_signal` ≠ 001.

## Timing
- `result` is purely combinational: zero latency, valid in the same cycle as the inputs. The dispatcher samples it at the next `clk` edge.
- `result_q` is updated at `posedge clk`:
  - `rst`=1: becomes 0 (synchronous reset).
  - otherwise: takes the value of `result`.
- Reset asserted mid-operation affects only `result_q`. `result` continues to track its inputs.
- There is no handshake and no internal state besides `result_q`. Back-to-back elements on consecutive cycles are allowed.

## Test plan
- **ADD, 8-bit:** PREV=CUR=000, OPIVV, `vs2`=0xF0, `vs1`=0x20, `vm`=1 -> `result`=0x10 (wraps). One cycle later `result_q`=0x10.
- **SUB, 32-bit, OPIVX:** PREV=CUR=010, `vs2`=5, `rs`=7 -> `result`=0xFFFFFFFE with upper 32 bits 0.
- **WADD / WADDU, 8→16:** PREV=000, CUR=001, `vs2`=0x80, `vs1`=0x80:
  - WADD -> 0xFF00;
  - WADDU -> 0x0100.
- **MADC / ADC with carry-in:** 8-bit, `vs2`=0xFF, `op2`=0x00, `vm`=0, `mask`=1:
  - MADC -> 1;
  - ADC -> 0x00.
- **SEXT4 and masking:** CUR=010, `vs2`=0x8F -> 0xFFFFFF8F. Any op with `vm`=0, `mask`=0, `vs2`=0x1234 at 16-bit -> 0x1234.
- **Reset / invalid:** `rst`=1 for one cycle -> `result_q`=0 next cycle. `opcode`=63 or `alu_signal`=000 -> `result`=0.
